alu_instr_encoder: RTL
======================

Name: alu_instr_encoder

Overview:
- Issue-side counterpart of the ALU instruction decoder.
- Accepts operation requests as separate fields, packs each one into a 32-bit R-type or I-type instruction word, and buffers the words in a small FIFO.
- Presents the words to the ALU-side consumer over a valid/ready handshake.
- Sits between the test/program sequencer and the ALU's Rtype/Itype inputs.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of fifo_count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous FIFO clear.
- req_valid  input  1  request present.
- req_ready  output  1  encoder can accept a request.
- req_op  input  4  operation select (see Behaviour).
- req_rd  input  5  destination register.
- req_rs  input  5  source register.
- req_rt  input  5  second source register (R-type only).
- req_shift  input  5  shift amount (R-type only).
- req_imm  input  16  immediate (I-type only).
- instr_valid  output  1  instr_word is valid.
- instr_ready  input  1  consumer accepts the word.
- instr_word  output  32  encoded instruction at the FIFO head.
- instr_is_itype  output  1  head word is I-type.
- fifo_count  output  CNT_W  number of occupied entries.
- err  output  1  sticky illegal-op flag (see Optional Feature).

Behaviour:
- One clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: FIFO empty, pointers 0, fifo_count=0, instr_valid=0, instr_word=0, instr_is_itype=0, err=0. req_ready=1 once reset is released.
- Op map (R-type): req_op 0..6 gives opcode 6'd0..6'd6 (AND, OR, NOT, MUL, DIV, SHR, SHL).
- Op map (I-type): req_op 8 gives opcode 6'b001010 (ADDI); req_op 9 gives 6'b001011 (SUBI).
- req_op values 7 and 10..15 are illegal.
- R-type encoding: [31:26]=opcode, [25:21]=rd, [20:16]=rs, [15:11]=rt, [10:6]=shift, [5:0]=func=6'b0.
- I-type encoding: [31:26]=opcode, [25:21]=rs, [20:16]=rd, [15:0]=imm.
- Unused request fields are ignored.
- Accept: a request is taken when req_valid && req_ready.
  - req_ready = (fifo_count < DEPTH) && !flush.
  - A push into a full FIFO is never taken, even if a pop happens in the same cycle.
- Latency: a word accepted in cycle N appears as instr_valid=1 in cycle N+1 when the FIFO was empty.
- Output is show-ahead: instr_word and instr_is_itype always reflect the head entry.
- Pop: occurs when instr_valid && instr_ready; the next entry appears in the following cycle.
- While instr_valid=1 and instr_ready=0, instr_word, instr_is_itype and instr_valid hold stable.
- Simultaneous push and pop (not full): both happen and fifo_count is unchanged.
- Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH and never goes below 0.
- flush:
  - Next cycle: count=0, pointers=0, instr_valid=0.
  - A request in the flush cycle is not accepted (req_ready=0).
  - A pop in the flush cycle is discarded.
  - err is not cleared by flush.
- Reset mid-operation: asynchronously returns every output to its reset value; in-flight entries are lost.

Optional Feature:
- Macro: ALU_ENC_ILLEGAL_CHK_EN.
- Defined:
  - An accepted request with an illegal req_op is dropped; no FIFO write.
  - err is set on the clock edge that accepts the request and stays set until reset.
  - req_ready behaves the same as for legal ops.
- Not defined:
  - An illegal req_op is encoded as an R-type word with opcode {2'b00, req_op}; err is tied to 0.

Test Plan:
- Reset then single AND (op0, rd=3, rs=1, rt=2, shift=0), instr_ready=1 -> instr_valid=1 one cycle later, instr_word=0x00611000, instr_is_itype=0, fifo_count returns to 0.
- ADDI (op8, rs=5, rd=7, imm=0x1234) -> instr_word=0x28A71234, instr_is_itype=1.
- SHL (op6, rd=4, rs=9, shift=3) -> instr_word=0x188900C0.
- Fill with instr_ready=0 and 5 requests -> first 4 accepted, req_ready=0 while fifo_count=4; raise instr_ready -> words emerge in order, one per cycle, and the 5th request is then accepted.
- Push and pop together at fifo_count=2 -> count stays 2 and order is preserved. Then flush at count=3 -> next cycle count=0, instr_valid=0.
- With ALU_ENC_ILLEGAL_CHK_EN defined, req_op=7 -> no word emitted, err=1 and it stays 1 through flush. Without the macro -> instr_word[31:26]=6'b000111, err=0.

Source files
------------

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: packs operation requests into 32-bit R-type or I-type
// instruction words and queues them in a show-ahead FIFO that feeds the ALU
// over a valid/ready handshake.
// Optional build macro ALU_ENC_ILLEGAL_CHK_EN: when it is defined, accepted
// requests with an illegal op are dropped and raise the sticky err flag. When
// it is not defined, illegal ops are encoded as R-type words and err stays 0.
module alu_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs,
    input  logic [4:0]       req_rt,
    input  logic [4:0]       req_shift,
    input  logic [15:0]      req_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr_word,
    output logic             instr_is_itype,
    output logic [CNT_W-1:0] fifo_count,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);

    // Each entry holds {is_itype, word}.
    logic [32:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [5:0]       w_opcode;
    logic             w_itype;
    logic [31:0]      w_word;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    // Translate the request op into an opcode and pack the word for its format.
    always_comb begin
        w_opcode = {2'b00, req_op};
        w_itype  = 1'b0;
        case (req_op)
            4'd8: begin
                w_opcode = 6'b001010;
                w_itype  = 1'b1;
            end
            4'd9: begin
                w_opcode = 6'b001011;
                w_itype  = 1'b1;
            end
            default: begin
                w_opcode = {2'b00, req_op};
                w_itype  = 1'b0;
            end
        endcase
        if (w_itype)
            w_word = {w_opcode, req_rs, req_rd, req_imm};
        else
            w_word = {w_opcode, req_rd, req_rs, req_rt, req_shift, 6'b000000};
    end

    assign req_ready   = (r_count < CNT_W'(DEPTH)) && !flush;
    assign w_accept    = req_valid && req_ready;
    assign instr_valid = (r_count != '0);
    // A pop during a flush is discarded along with the rest of the queue.
    assign w_pop       = instr_valid && instr_ready && !flush;

`ifdef ALU_ENC_ILLEGAL_CHK_EN
    logic w_legal;
    logic r_err;

    assign w_legal = (req_op <= 4'd6) || (req_op == 4'd8) || (req_op == 4'd9);
    assign w_push  = w_accept && w_legal;
    assign err     = r_err;

    // Sticky illegal-op flag; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_accept && !w_legal)
            r_err <= 1'b1;
    end
`else
    assign w_push = w_accept;
    assign err    = 1'b0;
`endif

    // Storage array; contents are don't-care until the count marks them valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {w_itype, w_word};
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign fifo_count     = r_count;
    assign instr_word     = instr_valid ? r_mem[r_rd_ptr][31:0] : 32'h0;
    assign instr_is_itype = instr_valid ? r_mem[r_rd_ptr][32] : 1'b0;

endmodule
